// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N:1 packet-locked stream multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Bundle of the per-channel input streams and the merged output stream.
// Latency: n/a (wiring only).
// Backpressure: n/a (wiring only).
// Ports: in_valid/in_ready/in_data/in_last (CHANNELS lanes), out_valid/out_ready/
//        out_data/out_last/out_channel (merged stream), busy (packet lock held).
// master = upstream producers plus downstream sink; slave = the multiplexer.
interface stream_mux_if import stream_mux_pkg::*; #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_w(CHANNELS)
) ();

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_last;
  logic [SEL_W-1:0]          out_channel;
  logic                      busy;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_channel, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_channel, busy
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational request picker: round-robin from ptr, or lowest index first.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller gates the grant with its own load condition.
// Ports: req (request vector), ptr (round-robin start), gnt (one-hot), idx (encoded), any.
module rr_arbiter import stream_mux_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int ARB_MODE = ARB_RR,
  parameter int SEL_W    = sel_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] gnt,
  output logic [SEL_W-1:0]    idx,
  output logic                any
);

  // Walk the channels in priority order and keep the first requester seen.
  always_comb begin : search
    logic [SEL_W-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ARB_MODE == ARB_FIXED) begin
        cand = SEL_W'(i);
      end else begin
        cand = SEL_W'((int'(ptr) + i) % CHANNELS);
      end
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N:1 stream multiplexer; the grant is held from a packet's first beat to its last.
// Latency: 1 cycle through the output register; one beat per cycle sustained.
// Backpressure: a full, stalled output register drops every in_ready in the same cycle.
// Ports: clk, rst (async, active-high), bus (stream_mux_if.slave: inputs, output, busy).
module stream_mux import stream_mux_pkg::*; #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic          clk,
  input  logic          rst,
  stream_mux_if.slave   bus
);

  localparam int SEL_W = sel_w(CHANNELS);

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    ptr, ptr_nxt;
  logic [SEL_W-1:0]    grant, grant_nxt;

  logic [CHANNELS-1:0] arb_gnt;
  logic [SEL_W-1:0]    arb_idx;
  logic                arb_any;

  logic [CHANNELS-1:0] sel_oh;
  logic [SEL_W-1:0]    win;
  logic [CHANNELS-1:0] ready;
  logic                can_load;
  logic                accept;
  logic                win_last;
  logic [WIDTH-1:0]    win_data;

  logic                out_valid_q;
  logic                out_last_q;
  logic [WIDTH-1:0]    out_data_q;
  logic [SEL_W-1:0]    out_channel_q;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] x);
    return (int'(x) == CHANNELS - 1) ? '0 : x + 1'b1;
  endfunction

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .ARB_MODE (ARB_MODE),
    .SEL_W    (SEL_W)
  ) u_arb (
    .req (bus.in_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign can_load = !out_valid_q || bus.out_ready;

  // While locked only the owning channel is steered, whatever the others request.
  always_comb begin
    sel_oh = arb_gnt;
    win    = arb_idx;
    if (state == LOCKED) begin
      sel_oh        = '0;
      sel_oh[grant] = 1'b1;
      win           = grant;
    end
  end

  // Held low during reset so nothing upstream sees an accept it cannot complete.
  assign ready    = (can_load && !rst) ? sel_oh : '0;
  assign accept   = |(ready & bus.in_valid);
  assign win_last = |(sel_oh & bus.in_last);

  always_comb begin
    win_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_oh[k]) win_data = win_data | bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (accept) begin
          if (win_last) begin
            ptr_nxt = next_idx(win);
          end else begin
            state_nxt = LOCKED;
            grant_nxt = win;
          end
        end
      end
      LOCKED: begin
        if (accept && win_last) begin
          state_nxt = IDLE;
          ptr_nxt   = next_idx(grant);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
    end
  end

  // Load wins over drain, so a simultaneous drain and load leaves no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      out_last_q    <= win_last;
      out_data_q    <= win_data;
      out_channel_q <= win;
    end else if (bus.out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_channel = out_channel_q;
  assign bus.busy        = (state == LOCKED);

endmodule

// File: tb/tb_stream_mux.sv
module tb_stream_mux;
  import stream_mux_pkg::*;

  localparam int C  = 4;
  localparam int W  = 16;
  localparam int SW = sel_w(C);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(W), .CHANNELS(C)) bus ();
  stream_mux_if #(.WIDTH(W), .CHANNELS(C)) fbus ();

  stream_mux #(.WIDTH(W), .CHANNELS(C), .ARB_MODE(ARB_RR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  stream_mux #(.WIDTH(W), .CHANNELS(C), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk (clk),
    .rst (rst),
    .bus (fbus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the owner of an open packet (or -1), the round-robin
  // start point and whether the output slot is occupied, updated per cycle
  // from the rules of the block; accepted beats are queued as expectations.
  typedef struct packed {
    logic [W-1:0]  d;
    logic          l;
    logic [SW-1:0] ch;
  } beat_t;

  beat_t exp_q[$];
  int    m_owner = -1;
  int    m_ptr   = 0;
  bit    m_full  = 1'b0;

  always @(negedge clk) begin : model
    logic [C-1:0] er;
    int w, k;
    bit found, cl;
    beat_t b;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_full  = 1'b0;
      exp_q.delete();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_out_channel", bus.out_channel, 0);
      check("rst_busy", bus.busy, 0);
    end else begin
      check("out_valid", bus.out_valid, m_full);
      check("busy", bus.busy, m_owner >= 0);
      cl    = !m_full || bus.out_ready;
      found = 1'b0;
      w     = 0;
      if (m_owner >= 0) begin
        w     = m_owner;
        found = 1'b1;
      end else begin
        for (int i = 0; i < C; i++) begin
          k = (m_ptr + i) % C;
          if (!found && bus.in_valid[k]) begin
            found = 1'b1;
            w     = k;
          end
        end
      end
      er = '0;
      if (found && cl) er[w] = 1'b1;
      check("in_ready", bus.in_ready, er);
      if (er[w] && bus.in_valid[w]) begin
        b.d  = bus.in_data[w*W +: W];
        b.l  = bus.in_last[w];
        b.ch = SW'(w);
        exp_q.push_back(b);
        if (b.l) begin
          m_owner = -1;
          m_ptr   = (w + 1) % C;
        end else begin
          m_owner = w;
        end
        m_full = 1'b1;
      end else if (bus.out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: every beat leaving the block must match the oldest expectation.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h ch %0d with no beat expected", bus.out_data, bus.out_channel);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", bus.out_data, e.d);
        check("sb_last", bus.out_last, e.l);
        check("sb_channel", bus.out_channel, e.ch);
      end
    end
  end

  int           rem [C];
  logic [C-1:0] hs;

  initial begin
    rst            = 1'b1;
    bus.in_valid   = '1;
    bus.in_last    = '1;
    bus.in_data    = 64'h0004_0003_0002_0001;
    bus.out_ready  = 1'b1;
    fbus.in_valid  = '1;
    fbus.in_last   = '1;
    fbus.in_data   = 64'h0F04_0F03_0F02_0F01;
    fbus.out_ready = 1'b1;
    for (int k = 0; k < C; k++) rem[k] = 0;

    // Reset held with every channel requesting.
    repeat (3) begin
      @(negedge clk);
      check("rst_fx_in_ready", fbus.in_ready, 0);
    end
    tick();
    rst          = 1'b0;
    bus.in_valid = '0;
    tick();

    // Round-robin fairness with single-beat packets on all channels.
    for (int k = 0; k < C; k++) bus.in_data[k*W +: W] = 16'(16'h00A0 + k);
    bus.in_last  = '1;
    bus.in_valid = '1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_order", bus.out_channel, i % 4);
      check("rr_no_bubble", bus.out_valid, 1);
      check("fx_channel", fbus.out_channel, 0);
      check("fx_ready", fbus.in_ready, 4'b0001);
    end
    bus.in_valid = '0;
    tick();

    // Single beat from channel 2, then the pointer must favour channel 3.
    bus.in_data[2*W +: W] = 16'hBEEF;
    bus.in_valid = 4'b0100;
    tick();
    check("single_valid", bus.out_valid, 1);
    check("single_data", bus.out_data, 16'hBEEF);
    check("single_channel", bus.out_channel, 2);
    bus.in_data[3*W +: W] = 16'h3333;
    bus.in_data[0*W +: W] = 16'h0A0A;
    bus.in_valid = 4'b1001;
    tick();
    check("ptr_after_single", bus.out_channel, 3);
    bus.in_valid = 4'b0001;
    tick();
    check("ptr_wrap", bus.out_channel, 0);
    bus.in_valid = '0;
    tick();

    // Packet lock: channel 1 owns the output while channel 0 keeps requesting.
    bus.in_data[0*W +: W] = 16'h00C0;
    bus.in_valid = 4'b0011;
    for (int b = 0; b < 3; b++) begin
      bus.in_data[1*W +: W] = 16'(16'h0011 * (b + 1));
      bus.in_last = (b == 2) ? 4'b0011 : 4'b0001;
      @(negedge clk);
      check("lock_ready", bus.in_ready, 4'b0010);
      tick();
      check("lock_data", bus.out_data, 16'h0011 * (b + 1));
      check("lock_channel", bus.out_channel, 1);
      check("lock_busy", bus.busy, b < 2);
    end
    bus.in_valid = 4'b0001;
    @(negedge clk);
    check("lock_release_ready", bus.in_ready, 4'b0001);
    tick();
    check("lock_next_channel", bus.out_channel, 0);
    check("lock_next_data", bus.out_data, 16'h00C0);
    bus.in_valid = '0;
    tick();

    // Backpressure for four cycles in the middle of a channel 2 packet.
    bus.in_last = 4'b0000;
    bus.in_data[2*W +: W] = 16'h0201;
    bus.in_valid = 4'b0100;
    tick();
    check("bp_first", bus.out_data, 16'h0201);
    bus.in_data[2*W +: W] = 16'h0202;
    bus.out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_ready", bus.in_ready, 0);
      tick();
      check("bp_hold", bus.out_data, 16'h0201);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_resume", bus.out_data, 16'h0202);
    bus.in_data[2*W +: W] = 16'h0203;
    bus.in_last = 4'b0100;
    tick();
    check("bp_last", bus.out_data, 16'h0203);
    bus.in_valid = '0;
    tick();

    // Reset after the second beat of a 3-beat packet from channel 1.
    bus.in_last = 4'b0000;
    bus.in_data[1*W +: W] = 16'h0101;
    bus.in_valid = 4'b0010;
    tick();
    bus.in_data[1*W +: W] = 16'h0102;
    tick();
    rst = 1'b1;
    bus.in_valid = '0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    tick();
    bus.in_data[2*W +: W] = 16'h0C02;
    bus.in_data[3*W +: W] = 16'h0301;
    bus.in_last  = 4'b0100;
    bus.in_valid = 4'b1100;
    tick();
    check("rst_ptr_zero", bus.out_channel, 2);
    bus.in_valid = 4'b1000;
    tick();
    check("rst_new_channel", bus.out_channel, 3);
    check("rst_new_busy", bus.busy, 1);
    bus.in_data[3*W +: W] = 16'h0302;
    bus.in_last = 4'b1000;
    tick();
    check("rst_new_last", bus.out_data, 16'h0302);
    check("rst_new_idle", bus.busy, 0);
    bus.in_valid = '0;
    tick();

    // Random traffic: packets of 1..4 beats, gaps, and random backpressure.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      hs = bus.in_valid & bus.in_ready;
      tick();
      for (int k = 0; k < C; k++) begin
        if (hs[k]) rem[k]--;
        if (rem[k] == 0) begin
          bus.in_valid[k] = 1'b0;
          if ($urandom_range(0, 2) == 0) rem[k] = $urandom_range(1, 4);
        end
        if (rem[k] > 0 && (hs[k] || !bus.in_valid[k])) begin
          bus.in_valid[k]       = ($urandom_range(0, 4) != 0);
          bus.in_data[k*W +: W] = {4'(k), 12'($urandom)};
          bus.in_last[k]        = (rem[k] == 1);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshakes and packet-locked arbitration. It generalises the team's fixed 16-bit 2:1 selector. Channel selection is produced internally, by round-robin or fixed-priority arbitration, instead of by an external select line. A grant is held from a packet's first beat until its `last` beat. The block merges several bus-master or peripheral streams onto one datapath stream.

## Interface
- `WIDTH`, 16, data width per channel.
- `CHANNELS`, 4, number of input channels, range 2..16.
- `ARB_MODE`, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `in_valid`  input  CHANNELS  per-channel beat valid.
- `in_ready`  output  CHANNELS  per-channel beat accept.
- `in_data`  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `in_last`  input  CHANNELS  per-channel end-of-packet flag.
- `out_valid`  output  1  output register holds a beat.
- `out_ready`  input  1  downstream accept.
- `out_data`  output  WIDTH  registered data.
- `out_last`  output  1  registered end-of-packet flag.
- `out_channel`  output  SEL_W  source index of the current output beat; SEL_W = max(1, clog2(CHANNELS)).
- `busy`  output  1  high while in LOCKED.

## Operation
- A handshake occurs on a channel when valid and ready are both high at a rising edge.
- `can_load = !out_valid || out_ready`. The single output register accepts a new beat every cycle, so full throughput is sustained.
- At most one `in_ready` bit is high in any cycle. `in_ready` is all zero when `can_load` is 0.
- The state machine has two states, IDLE and LOCKED. It is reset to IDLE.
- **IDLE**
  - The candidate channel `cand` is computed combinationally from `in_valid`.
  - ARB_MODE 0: search upward from pointer `ptr`, wrapping modulo CHANNELS.
  - ARB_MODE 1: lowest asserted index.
  - `in_ready[cand] = can_load`.
  - On a handshake with last=0: go to LOCKED and register `grant = cand`.
  - On a handshake with last=1: stay in IDLE and set `ptr = cand+1` (wrap).
- **LOCKED**
  - `in_ready[grant] = can_load`. All other channels see ready=0, whatever their valid.
  - On a handshake with last=1 from `grant`: go to IDLE and set `ptr = grant+1` (wrap).
  - If `in_valid[grant]` drops mid-packet, the block waits in LOCKED indefinitely. There is no timeout.
- Any accepted beat loads `out_data`, `out_last` and `out_channel` with the winner's data, last flag and index, and sets `out_valid = 1`.
- If there is no accepted beat and `out_ready` = 1, `out_valid` is cleared. The data fields hold their value.
- `ptr` changes only on a last-beat handshake and is ignored in ARB_MODE 1.
- Wrap: `ptr` = CHANNELS-1 plus 1 gives 0.

## Timing
- Latency is one cycle: a beat accepted at edge t is visible on `out_*` after edge t, until the downstream handshake.
- Throughput is one beat per cycle with `out_ready` held high.
- **Simultaneous load and drain:** when the output drains and a new input is accepted in the same cycle, `out_valid` stays 1 and the data is replaced with no bubble.
- **Backpressure:** `out_ready` = 0 with `out_valid` = 1 forces all `in_ready` low in the same cycle (combinational path `out_ready` -> `in_ready`).
- **Reset values:** `out_valid` 0, `out_data` 0, `out_last` 0, `out_channel` 0, `busy` 0, `in_ready` all 0, state IDLE, `ptr` 0, `grant` 0.
- **Reset mid-packet:** asserting `rst` mid-packet immediately drops the lock and clears the output register. The beat held there is lost. Upstream must restart the packet.
- **Single-beat packets:** packets with last on their first beat never enter LOCKED, so `busy` stays 0.

## Structure
- Package `stream_mux_pkg`:
  - state type (IDLE, LOCKED);
  - ARB_RR = 0 and ARB_FIXED = 1 constants;
  - SEL_W width function.
- Sub-module `rr_arbiter`, parametrised by CHANNELS and ARB_MODE:
  - inputs: request vector, `ptr`;
  - outputs: one-hot grant, encoded index, `any` flag.
  - It is purely combinational.
- The top module holds the FSM, `ptr`/`grant` registers, ready steering and the output register.

## Test plan
- **Reset:** hold `rst` 3 cycles with all `in_valid` high -> every output at its reset value and `in_ready` all 0 throughout.
- **Single beat:** CHANNELS=4, RR, `out_ready`=1; ch2 sends one beat 0xBEEF, last=1 -> next cycle `out_valid`=1, `out_data`=0xBEEF, `out_channel`=2, `ptr` becomes 3.
- **Round-robin fairness:** all four channels continuously send single-beat packets, `out_ready`=1 -> `out_channel` sequence 0,1,2,3,0,1 with no idle cycle. The same stimulus with ARB_MODE=1 -> always 0.
- **Packet lock:** ch1 sends a 3-beat packet 0x0011, 0x0022, 0x0033 (last on the third) while ch0 valid is held high -> ch0 ready stays 0 and output is 11, 22, 33 from ch1. Then ch0 is granted and `busy` falls after the last beat.
- **Backpressure:** `out_ready` low for 4 cycles mid-packet -> `out_data` stable, `in_ready` all 0, no beat lost or duplicated after release.
- **Reset mid-packet:** assert `rst` after the second beat of a 3-beat packet -> state IDLE, `out_valid` 0, `busy` 0. A subsequent new packet from ch3 is granted normally with `ptr` starting from 0.
